// File: rtl/formula_sum_isqrt_pkg.sv
// Shared types and sizing helpers for the summed-isqrt formula FSM.
package formula_sum_isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n_args);
        return $clog2(n_args + 1);
    endfunction

    // Wide enough for n_args maximal roots, so the accumulator never wraps.
    function automatic int unsigned res_width(input int unsigned n_args, input int unsigned arg_w);
        return arg_w / 2 + $clog2(n_args + 1);
    endfunction

endpackage

// File: rtl/formula_sum_isqrt_pipe_aware_fsm.sv
// Sums isqrt over an argument set using one shared pipelined isqrt; arguments are
// issued back to back and results are counted by valid pulses, so any latency works.
module formula_sum_isqrt_pipe_aware_fsm
    import formula_sum_isqrt_pkg::*;
#(
    parameter int unsigned N_ARGS = 3,
    parameter int unsigned ARG_W  = 32,
    parameter int unsigned RES_W  = res_width(N_ARGS, ARG_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arg_vld,
    output logic                    arg_rdy,
    input  logic [N_ARGS*ARG_W-1:0] args,
    output logic                    res_vld,
    output logic [RES_W-1:0]        res,
    output logic                    err,
    output logic                    isqrt_x_vld,
    output logic [ARG_W-1:0]        isqrt_x,
    input  logic                    isqrt_y_vld,
    input  logic [ARG_W/2-1:0]      isqrt_y
);

    localparam int unsigned CW = cnt_width(N_ARGS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_ARGS - 1);

    state_t                    state;
    logic [N_ARGS*ARG_W-1:0]   args_q;
    logic [CW-1:0]             issue_idx;
    logic [CW-1:0]             issued_cnt;
    logic [CW-1:0]             rcv_cnt;
    logic [RES_W-1:0]          acc;

    logic                      accept;
    logic                      y_take;
    logic                      y_stray;
    logic                      y_last;

    // arg[0] goes straight from the port in the accept cycle; later arguments
    // come from the low slot of a shifting copy of the set.
    always_comb begin
        arg_rdy     = (state == IDLE);
        accept      = arg_vld && arg_rdy;
        isqrt_x_vld = 1'b0;
        isqrt_x     = '0;
        if (accept) begin
            isqrt_x_vld = 1'b1;
            isqrt_x     = args[ARG_W-1:0];
        end else if (state == ISSUE) begin
            isqrt_x_vld = 1'b1;
            isqrt_x     = args_q[ARG_W-1:0];
        end
        y_take  = isqrt_y_vld && (rcv_cnt != issued_cnt);
        y_stray = isqrt_y_vld && (rcv_cnt == issued_cnt);
        y_last  = y_take && (rcv_cnt == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            args_q     <= '0;
            issue_idx  <= '0;
            issued_cnt <= '0;
            rcv_cnt    <= '0;
            acc        <= '0;
            res        <= '0;
            res_vld    <= 1'b0;
            err        <= 1'b0;
        end else begin
            res_vld <= 1'b0;

            if (isqrt_x_vld) begin
                issued_cnt <= issued_cnt + CNT_ONE;
            end

            if (y_stray) begin
                err <= 1'b1;
            end

            // Collection runs regardless of state so short latencies overlap issue.
            if (y_take) begin
                if (y_last) begin
                    res        <= acc + RES_W'(isqrt_y);
                    res_vld    <= 1'b1;
                    acc        <= '0;
                    rcv_cnt    <= '0;
                    issued_cnt <= '0;
                end else begin
                    acc     <= acc + RES_W'(isqrt_y);
                    rcv_cnt <= rcv_cnt + CNT_ONE;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        args_q    <= args >> ARG_W;
                        issue_idx <= CNT_ONE;
                        state     <= (N_ARGS > 1) ? ISSUE : WAIT;
                    end
                end
                ISSUE: begin
                    args_q    <= args_q >> ARG_W;
                    issue_idx <= issue_idx + CNT_ONE;
                    if (issue_idx == LAST_IDX) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (y_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_formula_sum_isqrt_pipe_aware_fsm.sv
// Directed bench: three formula instances (3, 1 and 5 arguments) each fed by a
// behavioural pipelined isqrt with adjustable latency, bubble delay and stray-pulse injection.
module tb_formula_sum_isqrt_pipe_aware_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // DUT-side signals
    logic          av0 = 1'b0, av1 = 1'b0, av2 = 1'b0;
    logic [95:0]   args0 = '0;
    logic [31:0]   args1 = '0;
    logic [159:0]  args2 = '0;
    wire           rdy0, rdy1, rdy2;
    wire           rv0, rv1, rv2;
    wire  [17:0]   res0;
    wire  [16:0]   res1;
    wire  [18:0]   res2;
    wire           err0, err1, err2;
    wire           xv0, xv1, xv2;
    wire  [31:0]   x0, x1, x2;
    wire           yv0, yv1, yv2;
    wire  [15:0]   y0, y1, y2;
    wire  [2:0]    rv = {rv2, rv1, rv0};

    // isqrt model state
    int            lat [3];
    logic          bub_en = 1'b0;
    logic [31:0]   bub_x  = '0;
    logic          inj    = 1'b0;
    logic [15:0]   inj_y  = '0;
    logic [15:0]   pv [3];
    logic [15:0]   py [3][16];
    logic [15:0]   nv [3];
    logic [15:0]   ny [3][16];
    logic [31:0]   xs [3];
    wire  [2:0]    xv = {xv2, xv1, xv0};

    assign xs[0] = x0;
    assign xs[1] = x1;
    assign xs[2] = x2;
    assign yv0 = pv[0][0] | inj;
    assign y0  = inj ? inj_y : py[0][0];
    assign yv1 = pv[1][0];
    assign y1  = py[1][0];
    assign yv2 = pv[2][0];
    assign y2  = py[2][0];

    function automatic logic [15:0] isqrt32(input logic [31:0] x);
        longint unsigned r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[15:0];
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            int  d;
            logic placed;
            d      = 0;
            placed = 1'b0;
            nv[k]  = pv[k] >> 1;
            for (int i = 0; i < 15; i++) ny[k][i] = py[k][i+1];
            ny[k][15] = '0;
            if (xv[k]) begin
                d = lat[k] - 1 + ((bub_en && xs[k] == bub_x) ? 3 : 0);
                for (int j = 0; j < 16; j++) begin
                    if (!placed && j >= d && !nv[k][j]) begin
                        nv[k][j] = 1'b1;
                        ny[k][j] = isqrt32(xs[k]);
                        placed   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            pv[k] <= rst ? '0 : nv[k];
            for (int i = 0; i < 16; i++) py[k][i] <= rst ? '0 : ny[k][i];
        end
    end

    formula_sum_isqrt_pipe_aware_fsm #(.N_ARGS(3), .ARG_W(32)) u_n3 (
        .clk(clk), .rst(rst), .arg_vld(av0), .arg_rdy(rdy0), .args(args0),
        .res_vld(rv0), .res(res0), .err(err0),
        .isqrt_x_vld(xv0), .isqrt_x(x0), .isqrt_y_vld(yv0), .isqrt_y(y0)
    );

    formula_sum_isqrt_pipe_aware_fsm #(.N_ARGS(1), .ARG_W(32)) u_n1 (
        .clk(clk), .rst(rst), .arg_vld(av1), .arg_rdy(rdy1), .args(args1),
        .res_vld(rv1), .res(res1), .err(err1),
        .isqrt_x_vld(xv1), .isqrt_x(x1), .isqrt_y_vld(yv1), .isqrt_y(y1)
    );

    formula_sum_isqrt_pipe_aware_fsm #(.N_ARGS(5), .ARG_W(32)) u_n5 (
        .clk(clk), .rst(rst), .arg_vld(av2), .arg_rdy(rdy2), .args(args2),
        .res_vld(rv2), .res(res2), .err(err2),
        .isqrt_x_vld(xv2), .isqrt_x(x2), .isqrt_y_vld(yv2), .isqrt_y(y2)
    );

    task automatic wait_res(input int k, input int t0, output int dt);
        dt = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rv[k]) begin
                dt = cyc - t0;
                break;
            end
        end
    endtask

    task automatic send0(input string tag, input logic [95:0] a, output int t0);
        @(posedge clk); #1;
        av0   = 1'b1;
        args0 = a;
        @(negedge clk);
        t0 = cyc;
        check({tag, "_rdy"}, rdy0, 1);
        @(posedge clk); #1;
        av0   = 1'b0;
        args0 = '0;
    endtask

    initial begin
        int t0, t1, dt, n_acc, n_res, first_dt;

        lat[0] = 4;
        lat[1] = 1;
        lat[2] = 4;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", {rdy2, rdy1, rdy0}, 3'b111);
        check("rst_res_vld", rv, 3'b000);
        check("rst_res", res0, 0);
        check("rst_err", {err2, err1, err0}, 3'b000);
        check("rst_xvld", xv0, 0);
        check("rst_x", x0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 3 args, L=4: consecutive issue and L+3 latency
        @(posedge clk); #1;
        av0   = 1'b1;
        args0 = {32'd25, 32'd16, 32'd9};
        @(negedge clk);
        t0 = cyc;
        check("t1_xvld0", xv0, 1);
        check("t1_x0", x0, 9);
        @(posedge clk); #1;
        av0   = 1'b0;
        args0 = {3{32'd1000}};
        @(negedge clk);
        check("t1_rdy_low", rdy0, 0);
        check("t1_x1", x0, 16);
        @(negedge clk);
        check("t1_x2", x0, 25);
        @(negedge clk);
        check("t1_xvld_off", xv0, 0);
        check("t1_x_zero", x0, 0);
        wait_res(0, t0, dt);
        check("t1_lat", dt, 7);
        check("t1_res", res0, 12);
        @(negedge clk);
        check("t1_pulse", rv0, 0);
        check("t1_hold", res0, 12);

        // back to back with arg_vld held high
        @(posedge clk); #1;
        av0   = 1'b1;
        args0 = {32'd4, 32'd1, 32'd0};
        @(negedge clk);
        t0 = cyc;
        check("t2_rdy", rdy0, 1);
        @(posedge clk); #1;
        args0 = {3{32'hFFFF_FFFF}};
        @(negedge clk);
        check("t2_rdy_low", rdy0, 0);
        wait_res(0, t0, dt);
        t1 = cyc;
        check("t2_lat_a", dt, 7);
        check("t2_res_a", res0, 3);
        check("t2_overlap_rdy", rdy0, 1);
        @(posedge clk); #1;
        av0   = 1'b0;
        args0 = '0;
        wait_res(0, t1, dt);
        check("t2_lat_b", dt, 7);
        check("t2_res_b", res0, 196605);

        // bubble on the 2nd result
        bub_en = 1'b1;
        bub_x  = 32'd49;
        send0("t4", {32'd64, 32'd49, 32'd36}, t0);
        wait_res(0, t0, dt);
        check("t4_lat", dt, 9);
        check("t4_res", res0, 21);
        bub_en = 1'b0;

        // 5 args, L=4
        @(posedge clk); #1;
        av2   = 1'b1;
        args2 = {32'd25, 32'd16, 32'd9, 32'd4, 32'd1};
        @(negedge clk);
        t0 = cyc;
        check("n5_rdy", rdy2, 1);
        @(posedge clk); #1;
        av2 = 1'b0;
        wait_res(2, t0, dt);
        check("n5_lat", dt, 9);
        check("n5_res", res2, 15);

        // 1 arg, L=1: arg held valid, accepted every other cycle
        @(posedge clk); #1;
        av1   = 1'b1;
        args1 = 32'd144;
        @(negedge clk);
        t0       = cyc;
        n_acc    = 0;
        n_res    = 0;
        first_dt = -1;
        check("n1_x", x1, 144);
        if (av1 && rdy1) n_acc++;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            if (av1 && rdy1) n_acc++;
            if (rv1) begin
                n_res++;
                if (first_dt < 0) first_dt = cyc - t0;
            end
        end
        check("n1_accepts", n_acc, 3);
        check("n1_results", n_res, 2);
        check("n1_lat", first_dt, 2);
        check("n1_res", res1, 12);
        @(posedge clk); #1;
        av1 = 1'b0;
        repeat (3) @(posedge clk);

        // reset one cycle after accept
        send0("t5", {32'd100, 32'd100, 32'd100}, t0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rdy", rdy0, 1);
        check("t5_xvld", xv0, 0);
        n_res = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rv0) n_res++;
        end
        check("t5_no_res", n_res, 0);
        check("t5_res_cleared", res0, 0);
        send0("t5b", {32'd4, 32'd4, 32'd4}, t0);
        wait_res(0, t0, dt);
        check("t5_res", res0, 6);

        // stray isqrt result while idle
        @(negedge clk);
        check("t6_err_before", err0, 0);
        @(posedge clk); #1;
        inj   = 1'b1;
        inj_y = 16'd7;
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        check("t6_err_set", err0, 1);
        send0("t6", {32'd25, 32'd16, 32'd9}, t0);
        wait_res(0, t0, dt);
        check("t6_res", res0, 12);
        check("t6_err_sticky", err0, 1);

        // 3 args, L=1: results overlap the issue phase
        lat[0] = 1;
        send0("l1", {32'd100, 32'd0, 32'd49}, t0);
        wait_res(0, t0, dt);
        check("l1_lat", dt, 4);
        check("l1_res", res0, 17);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
